// File: rtl/min_receive_fsm.sv
// Frame receiver: AA AA AA | ID | LEN | payload | CRC32 (MSB first) | 55.
// Strips byte stuffing, checks length and CRC-32, and publishes good frames.
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_byte,
  output logic [7:0]               o_id,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_err,
  output logic [3:0]               o_state
);

  localparam int          DW       = 8 * N_DATA_BYTE;
  localparam logic [7:0]  LEN_VAL  = 8'(N_DATA_BYTE);
  localparam logic [7:0]  LAST_IDX = 8'(N_DATA_BYTE - 1);
  localparam logic [31:0] CRC_INIT = '1;

  typedef enum logic [3:0] {
    S_SEARCH, S_HDR1, S_HDR2, S_ID, S_LEN, S_PAYLOAD,
    S_CRC3, S_CRC2, S_CRC1, S_CRC0, S_EOF
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      aa_cnt_q, aa_cnt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     rx_crc_q, rx_crc_d;
  logic [7:0]      id_sh_q, id_sh_d;
  logic [DW-1:0]   data_sh_q, data_sh_d;
  logic [7:0]      id_q, id_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            is_aa, in_body;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state, datapath and output pulse decode for one accepted byte
  always_comb begin
    state_d   = state_q;
    aa_cnt_d  = aa_cnt_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    id_sh_d   = id_sh_q;
    data_sh_d = data_sh_q;
    id_d      = id_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    is_aa     = (i_byte == 8'hAA);
    in_body   = !(state_q inside {S_SEARCH, S_HDR1, S_HDR2});

    if (i_en && i_valid) begin
      if (is_aa && aa_cnt_q >= 2'd2) begin
        // Third AA in a row: silently abandon whatever was in progress.
        state_d  = S_ID;
        aa_cnt_d = 2'd3;
        cnt_d    = '0;
      end else if (in_body && aa_cnt_q == 2'd2 && i_byte == 8'h55) begin
        // Stuffed 0x55 after two body AAs: dropped, only breaks the AA run.
        aa_cnt_d = '0;
      end else begin
        aa_cnt_d = is_aa ? aa_cnt_q + 2'd1 : 2'd0;
        case (state_q)
          S_SEARCH: if (is_aa) state_d = S_HDR1;
          S_HDR1:   state_d = is_aa ? S_HDR2 : S_SEARCH;
          S_HDR2:   state_d = is_aa ? S_ID : S_SEARCH;
          S_ID: begin
            id_sh_d = i_byte;
            crc_d   = crc_upd(CRC_INIT, i_byte);
            state_d = S_LEN;
          end
          S_LEN: begin
            crc_d = crc_upd(crc_q, i_byte);
            cnt_d = '0;
            if (i_byte == LEN_VAL) begin
              state_d = (N_DATA_BYTE == 0) ? S_CRC3 : S_PAYLOAD;
            end else begin
              err_d   = 1'b1;
              state_d = S_SEARCH;
            end
          end
          S_PAYLOAD: begin
            crc_d     = crc_upd(crc_q, i_byte);
            data_sh_d = DW'({data_sh_q, i_byte});
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = S_CRC3;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_CRC3: begin rx_crc_d = {rx_crc_q[23:0], i_byte}; state_d = S_CRC2; end
          S_CRC2: begin rx_crc_d = {rx_crc_q[23:0], i_byte}; state_d = S_CRC1; end
          S_CRC1: begin rx_crc_d = {rx_crc_q[23:0], i_byte}; state_d = S_CRC0; end
          S_CRC0: begin rx_crc_d = {rx_crc_q[23:0], i_byte}; state_d = S_EOF;  end
          S_EOF: begin
            if (i_byte == 8'h55 && (crc_q ^ 32'hFFFFFFFF) == rx_crc_q) begin
              valid_d = 1'b1;
              id_d    = id_sh_q;
              data_d  = data_sh_q;
            end else begin
              err_d = 1'b1;
            end
            state_d = S_SEARCH;
          end
          default: state_d = S_SEARCH;
        endcase
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_SEARCH;
      aa_cnt_q  <= '0;
      cnt_q     <= '0;
      crc_q     <= CRC_INIT;
      rx_crc_q  <= '0;
      id_sh_q   <= '0;
      data_sh_q <= '0;
      id_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aa_cnt_q  <= aa_cnt_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      id_sh_q   <= id_sh_d;
      data_sh_q <= data_sh_d;
      id_q      <= id_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_id    = id_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_min_receive_fsm.sv
// Directed bench for min_receive_fsm with a frame-level reference model.
module tb_min_receive_fsm;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst, en, vld;
  logic [7:0]   byt;
  logic [7:0]   o_id;
  logic [15:0]  o_data;
  logic         o_valid, o_err;
  logic [3:0]   o_state;

  min_receive_fsm #(.N_DATA_BYTE(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(vld), .i_byte(byt),
    .o_id(o_id), .o_data(o_data), .o_valid(o_valid), .o_err(o_err), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_v = 0;
  int cnt_e = 0;
  logic [7:0] tx_q[$];

  // Reference model: frame-level view of the byte stream
  int         m_aa = 0;
  bit         m_in = 0;
  logic [7:0] m_buf[$];
  logic [7:0] m_id = '0;
  logic [15:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] rx;
    if (b == 8'hAA) begin
      if (m_aa < 3) m_aa++;
      if (m_aa == 3) begin
        m_in = 1;
        m_buf.delete();
        return;
      end
    end else if (m_in && m_aa == 2 && b == 8'h55) begin
      m_aa = 0;
      return;
    end else begin
      m_aa = 0;
    end
    if (!m_in) return;
    m_buf.push_back(b);
    if (m_buf.size() == 2 && m_buf[1] != 8'(N)) begin
      m_err = 1'b1;
      m_in  = 0;
    end else if (m_buf.size() == 2 + N + 4 + 1) begin
      rx = {m_buf[N+2], m_buf[N+3], m_buf[N+4], m_buf[N+5]};
      if (b == 8'h55 && crc32(m_buf[0:N+1]) == rx) begin
        m_valid = 1'b1;
        m_id    = m_buf[0];
        m_data  = {m_buf[2], m_buf[3]};
      end else begin
        m_err = 1'b1;
      end
      m_in = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_aa = 0; m_in = 0; m_buf.delete();
      m_id = '0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (en && vld) model_byte(byt);
    end
  end

  // Cycle-by-cycle comparison against the model, plus pulse tallies
  always @(negedge clk) begin
    n_cmp++;
    if (o_valid !== m_valid || o_err !== m_err || o_id !== m_id || o_data !== m_data) begin
      n_bad++;
      $display("FAIL model t=%0t valid %b/%b err %b/%b id %h/%h data %h/%h (got/expected)",
               $time, o_valid, m_valid, o_err, m_err, o_id, m_id, o_data, m_data);
    end
    if (o_valid) cnt_v++;
    if (o_err)   cnt_e++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input logic [7:0] id, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] crc_x);
    logic [7:0]  body[$];
    logic [31:0] c;
    int run;
    body = {id, 8'(N), p0, p1};
    c = crc32(body);
    body.push_back(c[31:24]);
    body.push_back(c[23:16]);
    body.push_back(c[15:8]);
    body.push_back(c[7:0] ^ crc_x);
    tx_q = {8'hAA, 8'hAA, 8'hAA};
    run = 0;
    foreach (body[i]) begin
      tx_q.push_back(body[i]);
      if (body[i] == 8'hAA) begin
        run++;
        if (run == 2) begin
          tx_q.push_back(8'h55);
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
    tx_q.push_back(8'h55);
  endtask

  task automatic send_range(input int a, input int b);
    for (int i = a; i < b; i++) begin
      @(negedge clk);
      vld = 1'b1;
      byt = tx_q[i];
    end
    @(negedge clk);
    vld = 1'b0;
    byt = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clr;
    cnt_v = 0;
    cnt_e = 0;
  endtask

  logic [7:0] part[$];
  logic [7:0] junk[5];

  initial begin
    rst = 1'b0; en = 1'b1; vld = 1'b0; byt = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_id",    32'(o_id),    32'd0);
    chk("reset_data",  32'(o_data),  32'd0);
    chk("reset_pulse", {30'd0, o_valid, o_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Good frame, back-to-back bytes
    clr(); build(8'h01, 8'h12, 8'h34, 8'h00);
    send_range(0, tx_q.size());
    chk("good_nvalid", cnt_v, 1);
    chk("good_nerr",   cnt_e, 0);
    chk("good_id",     32'(o_id),   32'h01);
    chk("good_data",   32'(o_data), 32'h1234);
    chk("good_state",  32'(o_state), 32'd0);

    // Stuffed payload AA AA
    clr(); build(8'h01, 8'hAA, 8'hAA, 8'h00);
    chk("stuff_tx", {8'h0, tx_q[5], tx_q[6], tx_q[7]}, 32'h00AAAA55);
    send_range(0, tx_q.size());
    chk("stuff_nvalid", cnt_v, 1);
    chk("stuff_nerr",   cnt_e, 0);
    chk("stuff_data",   32'(o_data), 32'hAAAA);

    // Corrupt CRC[0]
    clr(); build(8'h01, 8'h12, 8'h34, 8'h01);
    send_range(0, tx_q.size());
    chk("crc_nvalid", cnt_v, 0);
    chk("crc_nerr",   cnt_e, 1);
    chk("crc_data",   32'(o_data), 32'hAAAA);

    // Wrong length
    clr(); tx_q = {8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h03};
    send_range(0, tx_q.size());
    chk("len_nerr",   cnt_e, 1);
    chk("len_nvalid", cnt_v, 0);
    chk("len_state",  32'(o_state), 32'd0);

    // Resync: abort after first payload byte, then a full frame
    clr(); build(8'h01, 8'h12, 8'h34, 8'h00);
    part.delete();
    for (int i = 0; i < 6; i++) part.push_back(tx_q[i]);
    build(8'h05, 8'h56, 8'h78, 8'h00);
    for (int i = 5; i >= 0; i--) tx_q.push_front(part[i]);
    send_range(0, tx_q.size());
    chk("resync_nvalid", cnt_v, 1);
    chk("resync_nerr",   cnt_e, 0);
    chk("resync_id",     32'(o_id),   32'h05);
    chk("resync_data",   32'(o_data), 32'h5678);

    // Reset mid-payload, then a good frame
    clr(); build(8'h07, 8'h9A, 8'hBC, 8'h00);
    send_range(0, 6);
    chk("rst_pre_state", 32'(o_state), 32'd5);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_id",    32'(o_id),    32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_npulse", cnt_v + cnt_e, 0);
    send_range(0, tx_q.size());
    chk("rst_nvalid", cnt_v, 1);
    chk("rst_nerr",   cnt_e, 0);
    chk("rst_id2",    32'(o_id),   32'h07);
    chk("rst_data2",  32'(o_data), 32'h9ABC);

    // Enable low mid-frame: junk ignored, frame completes afterwards
    clr(); build(8'h09, 8'h11, 8'h22, 8'h00);
    send_range(0, 5);
    chk("en_pre_state", 32'(o_state), 32'd5);
    en = 1'b0;
    junk = '{8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h55};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vld = 1'b1;
      byt = junk[i];
    end
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    chk("en_hold_state", 32'(o_state), 32'd5);
    en = 1'b1;
    send_range(5, tx_q.size());
    chk("en_nvalid", cnt_v, 1);
    chk("en_nerr",   cnt_e, 0);
    chk("en_id",     32'(o_id),   32'h09);
    chk("en_data",   32'(o_data), 32'h1122);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
